// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared front-end definitions for the fetch PC sequencer: address width,
// default reset PC and the sequencer state encoding.
package fetch_pc_ctrl_pkg;

    localparam int unsigned AddrW    = 24;
    localparam int unsigned BootCntW = 4;
    localparam int unsigned CountW   = 32;

    localparam logic [AddrW-1:0] ResetPcDefault = 24'h000000;

    typedef enum logic [1:0] {
        StBoot  = 2'd0,
        StRun   = 2'd1,
        StStall = 2'd2,
        StHalt  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_next.sv
// Combinational next-PC select: redirect beats pending beats sequential step.
// The increment wraps naturally at the address width.
module fetch_pc_next
    import fetch_pc_ctrl_pkg::*;
#(
    parameter int unsigned PC_STEP = 1
) (
    input  logic [AddrW-1:0] pc_i,
    input  logic             inc_en_i,
    input  logic             redirect_valid_i,
    input  logic [AddrW-1:0] redirect_pc_i,
    input  logic             pend_valid_i,
    input  logic [AddrW-1:0] pend_pc_i,
    output logic [AddrW-1:0] next_pc_o,
    output logic             pend_used_o
);

    localparam logic [AddrW-1:0] Step = AddrW'(PC_STEP);

    always_comb begin
        next_pc_o   = pc_i;
        pend_used_o = 1'b0;
        if (redirect_valid_i) begin
            next_pc_o = redirect_pc_i;
        end else if (pend_valid_i) begin
            next_pc_o   = pend_pc_i;
            pend_used_o = 1'b1;
        end else if (inc_en_i) begin
            next_pc_o = pc_i + Step;
        end
    end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch program-counter sequencer: boot delay, sequential fetch, stall,
// redirect and halt/resume. All outputs come straight from flops.
module fetch_pc_ctrl
    import fetch_pc_ctrl_pkg::*;
#(
    parameter logic [AddrW-1:0] RESET_PC    = ResetPcDefault,
    parameter int unsigned      BOOT_CYCLES = 2,
    parameter int unsigned      PC_STEP     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_in,
    input  logic              redirect_valid,
    input  logic [AddrW-1:0]  redirect_pc,
    input  logic              halt_req,
    input  logic              resume_req,
    output logic [AddrW-1:0]  pc_out,
    output logic              enable_out,
    output logic              halted,
    output logic [CountW-1:0] fetch_count
);

    localparam logic [BootCntW-1:0] BootInit = BootCntW'(BOOT_CYCLES - 1);

    fetch_state_e       state_q, state_d;
    logic [AddrW-1:0]   pc_q, pc_d;
    logic               enable_q, enable_d;
    logic               halted_q, halted_d;
    logic [CountW-1:0]  fetch_count_q, fetch_count_d;
    logic [BootCntW-1:0] boot_cnt_q, boot_cnt_d;
    logic               pend_valid_q, pend_valid_d;
    logic [AddrW-1:0]   pend_pc_q, pend_pc_d;

    logic               inc_en;
    logic [AddrW-1:0]   next_pc;
    logic               pend_used;

    fetch_pc_next #(
        .PC_STEP (PC_STEP)
    ) u_next (
        .pc_i             (pc_q),
        .inc_en_i         (inc_en),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .pend_valid_i     (pend_valid_q),
        .pend_pc_i        (pend_pc_q),
        .next_pc_o        (next_pc),
        .pend_used_o      (pend_used)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        boot_cnt_d    = boot_cnt_q;
        pend_valid_d  = pend_valid_q;
        pend_pc_d     = pend_pc_q;
        inc_en        = 1'b0;
        fetch_count_d = fetch_count_q + {{(CountW-1){1'b0}}, enable_q};

        unique case (state_q)
            StBoot: begin
                if (boot_cnt_q == '0) begin
                    // Leaving boot: a redirect this cycle is the latest and wins over pending.
                    state_d      = StRun;
                    pc_d         = next_pc;
                    pend_valid_d = 1'b0;
                end else begin
                    boot_cnt_d = boot_cnt_q - 1'b1;
                    if (redirect_valid) begin
                        pend_valid_d = 1'b1;
                        pend_pc_d    = redirect_pc;
                    end
                end
            end
            StRun: begin
                // A stall rejects the current fetch, so it is re-issued without stepping.
                inc_en = halt_req | ~stall_in;
                pc_d   = next_pc;
                if (halt_req) begin
                    state_d = StHalt;
                end else if (stall_in) begin
                    state_d = StStall;
                end
            end
            StStall: begin
                pc_d = next_pc;
                if (halt_req) begin
                    state_d = StHalt;
                end else if (!stall_in) begin
                    state_d = StRun;
                end
            end
            StHalt: begin
                pc_d = next_pc;
                if (resume_req && !halt_req) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StBoot;
            end
        endcase

        if (state_q != StBoot && pend_used) begin
            pend_valid_d = 1'b0;
        end

        enable_d = (state_d == StRun);
        halted_d = (state_d == StHalt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StBoot;
            pc_q          <= RESET_PC;
            enable_q      <= 1'b0;
            halted_q      <= 1'b0;
            fetch_count_q <= '0;
            boot_cnt_q    <= BootInit;
            pend_valid_q  <= 1'b0;
            pend_pc_q     <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            enable_q      <= enable_d;
            halted_q      <= halted_d;
            fetch_count_q <= fetch_count_d;
            boot_cnt_q    <= boot_cnt_d;
            pend_valid_q  <= pend_valid_d;
            pend_pc_q     <= pend_pc_d;
        end
    end

    assign pc_out      = pc_q;
    assign enable_out  = enable_q;
    assign halted      = halted_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl with RESET_PC=0x100, BOOT_CYCLES=2, PC_STEP=1.
module tb_fetch_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_in = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [23:0] redirect_pc = '0;
    logic        halt_req = 1'b0;
    logic        resume_req = 1'b0;
    logic [23:0] pc_out;
    logic        enable_out;
    logic        halted;
    logic [31:0] fetch_count;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    fetch_pc_ctrl #(
        .RESET_PC    (24'h000100),
        .BOOT_CYCLES (2),
        .PC_STEP     (1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_in       (stall_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .resume_req     (resume_req),
        .pc_out         (pc_out),
        .enable_out     (enable_out),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic en, input logic [23:0] pc,
                           input logic hlt);
        chk({tag, ".en"}, {31'b0, enable_out}, {31'b0, en});
        chk({tag, ".pc"}, {8'b0, pc_out}, {8'b0, pc});
        chk({tag, ".halted"}, {31'b0, halted}, {31'b0, hlt});
    endtask

    task automatic redirect_to(input logic [23:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        chk_out("reset", 1'b0, 24'h000100, 1'b0);
        chk("reset.count", fetch_count, 32'd0);
        rst = 1'b0;

        // Boot delay of two idle cycles, then sequential fetch
        tick();
        chk_out("boot1", 1'b0, 24'h000100, 1'b0);
        tick();
        chk_out("first_fetch", 1'b1, 24'h000100, 1'b0);
        tick();
        chk_out("seq1", 1'b1, 24'h000101, 1'b0);
        tick();
        chk_out("seq2", 1'b1, 24'h000102, 1'b0);
        tick();
        chk("count_after_3", fetch_count, 32'd3);

        // Stall for three cycles at 0x10
        redirect_to(24'h000010);
        tick();
        redirect_valid = 1'b0;
        chk_out("at_10", 1'b1, 24'h000010, 1'b0);
        stall_in = 1'b1;
        tick();
        chk_out("stall1", 1'b0, 24'h000010, 1'b0);
        tick();
        chk_out("stall2", 1'b0, 24'h000010, 1'b0);
        tick();
        chk_out("stall3", 1'b0, 24'h000010, 1'b0);
        stall_in = 1'b0;
        tick();
        chk_out("stall_reissue", 1'b1, 24'h000010, 1'b0);
        tick();
        chk_out("stall_next", 1'b1, 24'h000011, 1'b0);
        chk("count_after_stall", fetch_count, 32'd6);

        // Redirect in RUN, then redirect during stall
        redirect_to(24'h000020);
        tick();
        redirect_to(24'h00ABCD);
        tick();
        redirect_valid = 1'b0;
        chk_out("redir_run", 1'b1, 24'h00ABCD, 1'b0);
        tick();
        chk_out("redir_run_inc", 1'b1, 24'h00ABCE, 1'b0);
        stall_in = 1'b1;
        tick();
        chk_out("redir_stall_enter", 1'b0, 24'h00ABCE, 1'b0);
        redirect_to(24'h00ABCD);
        tick();
        redirect_valid = 1'b0;
        chk_out("redir_in_stall", 1'b0, 24'h00ABCD, 1'b0);
        stall_in = 1'b0;
        tick();
        chk_out("redir_stall_release", 1'b1, 24'h00ABCD, 1'b0);
        tick();
        chk_out("redir_stall_inc", 1'b1, 24'h00ABCE, 1'b0);
        chk("count_after_redir", fetch_count, 32'd11);

        // Address wrap
        redirect_to(24'hFFFFFF);
        tick();
        redirect_valid = 1'b0;
        chk_out("at_max", 1'b1, 24'hFFFFFF, 1'b0);
        tick();
        chk_out("wrap", 1'b1, 24'h000000, 1'b0);

        // Halt, redirect while halted, halt+resume, resume
        redirect_to(24'h000040);
        tick();
        redirect_valid = 1'b0;
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk_out("halt", 1'b0, 24'h000041, 1'b1);
        tick();
        chk_out("halt_hold", 1'b0, 24'h000041, 1'b1);
        redirect_to(24'h000200);
        tick();
        redirect_valid = 1'b0;
        chk_out("halt_redirect", 1'b0, 24'h000200, 1'b1);
        halt_req   = 1'b1;
        resume_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk_out("halt_and_resume", 1'b0, 24'h000200, 1'b1);
        tick();
        resume_req = 1'b0;
        chk_out("resume", 1'b1, 24'h000200, 1'b0);
        chk("count_at_resume", fetch_count, 32'd15);
        tick();
        chk_out("resume_inc", 1'b1, 24'h000201, 1'b0);

        // Halt beats stall; same-cycle redirect is applied
        halt_req = 1'b1;
        stall_in = 1'b1;
        redirect_to(24'h000333);
        tick();
        halt_req = 1'b0;
        stall_in = 1'b0;
        redirect_valid = 1'b0;
        chk_out("halt_over_stall", 1'b0, 24'h000333, 1'b1);
        resume_req = 1'b1;
        tick();
        chk_out("resume2", 1'b1, 24'h000333, 1'b0);
        tick();
        resume_req = 1'b0;
        chk_out("resume_in_run_ignored", 1'b1, 24'h000334, 1'b0);

        // Asynchronous reset mid-RUN
        redirect_to(24'h000055);
        tick();
        redirect_valid = 1'b0;
        chk_out("at_55", 1'b1, 24'h000055, 1'b0);
        chk("count_before_rst", fetch_count, 32'd19);
        #2;
        rst = 1'b1;
        #1;
        chk_out("async_rst", 1'b0, 24'h000100, 1'b0);
        chk("async_rst.count", fetch_count, 32'd0);
        tick();
        rst = 1'b0;

        // Redirect during boot is fetched first
        redirect_to(24'h000300);
        tick();
        redirect_valid = 1'b0;
        chk_out("boot_pending", 1'b0, 24'h000100, 1'b0);
        tick();
        chk_out("boot_pending_fetch", 1'b1, 24'h000300, 1'b0);
        tick();
        chk_out("boot_pending_inc", 1'b1, 24'h000301, 1'b0);
        chk("count_after_reboot", fetch_count, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- Program-counter sequencer for the front end.
- Drives the PC and enable inputs of the instruction-address stage.
- Sequences boot delay, sequential fetch, stall, branch/exception redirect, and halt/resume.
- Sits between the execute/control redirect sources and the instruction-address stage; owns the architectural fetch PC.

Parameters:
- RESET_PC, 24'h000000, fetch address loaded on reset.
- BOOT_CYCLES, 2, idle cycles after reset before the first fetch (memory warm-up); legal range 1..15.
- PC_STEP, 1, increment per sequential fetch (word-addressed).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- stall_in  in  1  downstream back-pressure; hold PC, suppress fetch
- redirect_valid  in  1  redirect request (branch/jump/exception), single-cycle pulse
- redirect_pc  in  24  redirect target
- halt_req  in  1  stop fetching after the current cycle
- resume_req  in  1  leave HALT
- pc_out  out  24  fetch PC, feeds the instruction-address stage's pc input
- enable_out  out  1  fetch-valid qualifier, feeds that stage's enable
- halted  out  1  high while in HALT
- fetch_count  out  32  number of cycles with enable_out=1 since reset; wraps

Behaviour:
- One clock domain on clk.
- Reset is asynchronous and active-high on rst; reset values: pc_out=RESET_PC, enable_out=0, halted=0, fetch_count=0, state=BOOT, boot counter=BOOT_CYCLES-1, pending redirect cleared.
- All outputs are registered; enable_out and pc_out change only on clk edges (or on rst).
- States: BOOT, RUN, STALL, HALT.
- BOOT:
  - enable_out=0; counter decrements each cycle.
  - When the counter reaches 0, go to RUN; enable_out=1 from the next cycle.
  - Total idle cycles after reset deassert = BOOT_CYCLES.
  - A redirect during BOOT is stored in the pending register (latest wins); it is loaded into pc_out on the BOOT->RUN transition.
- RUN:
  - enable_out=1.
  - Next-PC priority: redirect_valid (redirect_pc) > pending (pending_pc, then clear) > pc_out+PC_STEP.
  - Addition is mod 2^24: 24'hFFFFFF+1 = 24'h000000.
- RUN->STALL when stall_in=1: enable_out=0 next cycle, pc_out holds.
- STALL:
  - A redirect_valid updates pc_out immediately (next cycle) while enable_out stays 0.
  - When stall_in=0, go to RUN; the first fetch re-issues the held or redirected PC, with no increment.
- HALT:
  - halt_req in RUN or STALL goes to HALT next cycle: enable_out=0, halted=1, pc_out holds the next-to-fetch PC.
  - HALT takes priority over stall_in.
  - A redirect in the same cycle as halt_req is applied to pc_out.
  - A redirect while in HALT updates pc_out.
  - resume_req goes to RUN next cycle with halted=0, enable_out=1, fetching pc_out.
  - halt_req and resume_req together: halt wins (state stays or becomes HALT).
  - resume_req outside HALT is ignored.
- fetch_count increments in every cycle where enable_out=1; 32-bit wrap, no saturation.
- rst asserted mid-operation: immediate return to reset values; pending redirect discarded.
- No combinational path from any input to any output.

Decomposition:
- Shared package (front-end pkg): state enum type for BOOT/RUN/STALL/HALT, 24-bit address width constant, RESET_PC default constant.
- One natural sub-module: fetch_pc_next, purely combinational next-PC mux/adder implementing the redirect > pending > increment priority and wrap. The FSM, counters and registers stay in the top.

Test Plan:
- Reset release, BOOT_CYCLES=2, RESET_PC=24'h000100 -> enable_out=0 for 2 cycles, then pc_out 0x100, 0x101, 0x102 with enable_out=1; fetch_count=3 after 3 fetches.
- RUN at pc 0x000010, stall_in high 3 cycles -> enable_out low 3 cycles, pc_out holds 0x000010; after release, fetch 0x000010 then 0x000011.
- redirect_valid=1, redirect_pc=0x00ABCD, in RUN at 0x000020 -> next pc_out=0x00ABCD, then 0x00ABCE; redirect during stall -> first fetch after release is 0x00ABCD.
- pc_out=24'hFFFFFF in RUN -> next pc_out=24'h000000, enable_out stays 1.
- halt_req at pc 0x000040 -> halted=1, enable_out=0, pc_out=0x000041 held; redirect to 0x000200 while halted; resume_req -> fetch 0x000200; halt_req+resume_req together in HALT -> stays halted.
- rst asserted asynchronously mid-RUN at pc 0x000055 -> outputs immediately return to RESET_PC/0; a redirect pulsed during BOOT to 0x000300 is fetched first after BOOT.
